// File: rtl/i2c_master_word_ctl.sv
// ---------------------------------------------------------------------------
// i2c_master_word_ctl
// Byte/word sequencer sitting between the register file and the I2C bit
// controller. One WRITE/READ command moves NBYTES bytes MSB first, each byte
// followed by an ACK bit (sampled on writes, driven on reads). START, STOP and
// RESTART are passed straight through as single bit-level commands.
//
// Ports
//   i_sysclk, i_nReset   clock, asynchronous active-low reset
//   i_enable             core enable, low aborts to IDLE without an ack
//   i_cmd_trig, i_cmd    command strobe and code (1 START,2 STOP,3 WRITE,
//                        4 READ,5 RESTART; others ignored)
//   i_last_nak           READ: NAK the final byte instead of ACKing it
//   i_data / o_data      write data in / read data out (DATA_W bits)
//   o_cmd_ack            one-cycle completion/abort pulse
//   o_rx_nak             slave ACK bit of the last written byte (1 = NAK)
//   o_al                 sticky arbitration-lost flag
//   o_busy               sequencer not idle
//   o_bytes_done         bytes completed by the last WRITE/READ
//   o_bit_cmd, o_bit_din command and data bit towards the bit controller
//   i_bit_done, i_bit_dout, i_arblost  bit controller responses
// ---------------------------------------------------------------------------
module i2c_master_word_ctl #(
    parameter int  NBYTES      = 2,
    parameter bit  STOP_ON_NAK = 1'b1,
    parameter int  CW          = $clog2(NBYTES + 1),
    localparam int DATA_W      = 8 * NBYTES
) (
    input  logic              i_sysclk,
    input  logic              i_nReset,
    input  logic              i_enable,
    input  logic              i_cmd_trig,
    input  logic [2:0]        i_cmd,
    input  logic              i_last_nak,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_cmd_ack,
    output logic              o_rx_nak,
    output logic              o_al,
    output logic              o_busy,
    output logic [CW-1:0]     o_bytes_done,
    output logic [2:0]        o_bit_cmd,
    output logic              o_bit_din,
    input  logic              i_bit_done,
    input  logic              i_bit_dout,
    input  logic              i_arblost
);

    localparam logic [2:0] CMD_IDLE    = 3'd0;
    localparam logic [2:0] CMD_START   = 3'd1;
    localparam logic [2:0] CMD_STOP    = 3'd2;
    localparam logic [2:0] CMD_WRITE   = 3'd3;
    localparam logic [2:0] CMD_READ    = 3'd4;
    localparam logic [2:0] CMD_RESTART = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_STOP, ST_RESTART,
        ST_WR_BIT, ST_WR_ACK, ST_RD_BIT, ST_RD_ACK
    } state_t;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic [2:0]          bit_cnt_r, bit_cnt_s;
    logic [CW-1:0]       byte_cnt_r, byte_cnt_s;
    logic                last_nak_r, last_nak_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                cmd_ack_r, cmd_ack_s;
    logic                rx_nak_r, rx_nak_s;
    logic                al_r, al_s;
    logic                busy_r, busy_s;
    logic [CW-1:0]       bytes_done_r, bytes_done_s;
    logic [2:0]          bit_cmd_r, bit_cmd_s;
    logic                bit_din_r, bit_din_s;
    logic [CW-1:0]       byte_inc_s;
    logic [DATA_W-1:0]   shift_wr_s;
    logic [DATA_W-1:0]   shift_rd_s;
    logic                last_byte_s;

    // Next-state and next-output logic; every output is computed here and
    // registered, so the bit command appears the cycle after its cause.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        byte_cnt_s   = byte_cnt_r;
        last_nak_s   = last_nak_r;
        data_s       = data_r;
        cmd_ack_s    = 1'b0;
        rx_nak_s     = rx_nak_r;
        al_s         = al_r;
        bytes_done_s = bytes_done_r;
        bit_cmd_s    = bit_cmd_r;
        bit_din_s    = bit_din_r;
        byte_inc_s   = byte_cnt_r + CW'(1);
        last_byte_s  = (byte_inc_s == CW'(NBYTES));
        shift_wr_s   = {shift_r[DATA_W-2:0], 1'b1};
        shift_rd_s   = {shift_r[DATA_W-2:0], i_bit_dout};

        if (!i_enable) begin
            state_s   = ST_IDLE;
            bit_cmd_s = CMD_IDLE;
            bit_din_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            if (i_cmd_trig) begin
                case (i_cmd)
                    CMD_START: begin
                        state_s = ST_START;  bit_cmd_s = CMD_START;
                        bit_din_s = 1'b1;    al_s = 1'b0;
                    end
                    CMD_STOP: begin
                        state_s = ST_STOP;   bit_cmd_s = CMD_STOP;
                        bit_din_s = 1'b1;    al_s = 1'b0;
                    end
                    CMD_RESTART: begin
                        state_s = ST_RESTART; bit_cmd_s = CMD_RESTART;
                        bit_din_s = 1'b1;     al_s = 1'b0;
                    end
                    CMD_WRITE: begin
                        state_s    = ST_WR_BIT;
                        shift_s    = i_data;
                        byte_cnt_s = {CW{1'b0}};
                        bit_cnt_s  = 3'd7;
                        bit_cmd_s  = CMD_WRITE;
                        bit_din_s  = i_data[DATA_W-1];
                        al_s       = 1'b0;
                    end
                    CMD_READ: begin
                        state_s    = ST_RD_BIT;
                        byte_cnt_s = {CW{1'b0}};
                        bit_cnt_s  = 3'd7;
                        last_nak_s = i_last_nak;
                        bit_cmd_s  = CMD_READ;
                        bit_din_s  = 1'b1;
                        al_s       = 1'b0;
                    end
                    default: begin
                        // IDLE and undefined codes are dropped silently
                        state_s = ST_IDLE;
                    end
                endcase
            end else begin
                state_s = ST_IDLE;
            end
        end else if (i_arblost) begin
            // Arbitration loss outranks a coincident bit_done
            state_s   = ST_IDLE;
            bit_cmd_s = CMD_IDLE;
            bit_din_s = 1'b1;
            al_s      = 1'b1;
            cmd_ack_s = 1'b1;
            if (state_r == ST_WR_BIT || state_r == ST_WR_ACK ||
                state_r == ST_RD_BIT || state_r == ST_RD_ACK) begin
                bytes_done_s = byte_cnt_r;
            end else begin
                bytes_done_s = bytes_done_r;
            end
        end else if (i_bit_done) begin
            case (state_r)
                ST_START, ST_STOP, ST_RESTART: begin
                    state_s   = ST_IDLE;
                    bit_cmd_s = CMD_IDLE;
                    bit_din_s = 1'b1;
                    cmd_ack_s = 1'b1;
                end
                ST_WR_BIT: begin
                    shift_s = shift_wr_s;
                    if (bit_cnt_r == 3'd0) begin
                        state_s   = ST_WR_ACK;
                        bit_cnt_s = 3'd7;
                        bit_cmd_s = CMD_READ;
                        bit_din_s = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                        bit_cmd_s = CMD_WRITE;
                        bit_din_s = shift_wr_s[DATA_W-1];
                    end
                end
                ST_WR_ACK: begin
                    rx_nak_s   = i_bit_dout;
                    byte_cnt_s = byte_inc_s;
                    if (last_byte_s || (STOP_ON_NAK && i_bit_dout)) begin
                        state_s      = ST_IDLE;
                        bit_cmd_s    = CMD_IDLE;
                        bit_din_s    = 1'b1;
                        bytes_done_s = byte_inc_s;
                        cmd_ack_s    = 1'b1;
                    end else begin
                        // shift_r already holds the next byte at the top
                        state_s   = ST_WR_BIT;
                        bit_cmd_s = CMD_WRITE;
                        bit_din_s = shift_r[DATA_W-1];
                    end
                end
                ST_RD_BIT: begin
                    shift_s = shift_rd_s;
                    if (bit_cnt_r == 3'd0) begin
                        state_s   = ST_RD_ACK;
                        bit_cnt_s = 3'd7;
                        bit_cmd_s = CMD_WRITE;
                        bit_din_s = last_byte_s & last_nak_r;
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                        bit_cmd_s = CMD_READ;
                        bit_din_s = 1'b1;
                    end
                end
                ST_RD_ACK: begin
                    byte_cnt_s = byte_inc_s;
                    if (last_byte_s) begin
                        state_s      = ST_IDLE;
                        bit_cmd_s    = CMD_IDLE;
                        bit_din_s    = 1'b1;
                        data_s       = shift_r;
                        bytes_done_s = byte_inc_s;
                        cmd_ack_s    = 1'b1;
                    end else begin
                        state_s   = ST_RD_BIT;
                        bit_cmd_s = CMD_READ;
                        bit_din_s = 1'b1;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    bit_cmd_s = CMD_IDLE;
                    bit_din_s = 1'b1;
                end
            endcase
        end else begin
            // Waiting for the bit controller: hold the current command
            bit_cmd_s = bit_cmd_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i_sysclk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_r      <= ST_IDLE;
            shift_r      <= {DATA_W{1'b1}};
            bit_cnt_r    <= 3'd7;
            byte_cnt_r   <= {CW{1'b0}};
            last_nak_r   <= 1'b0;
            data_r       <= {DATA_W{1'b1}};
            cmd_ack_r    <= 1'b0;
            rx_nak_r     <= 1'b0;
            al_r         <= 1'b0;
            busy_r       <= 1'b0;
            bytes_done_r <= {CW{1'b0}};
            bit_cmd_r    <= CMD_IDLE;
            bit_din_r    <= 1'b1;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            byte_cnt_r   <= byte_cnt_s;
            last_nak_r   <= last_nak_s;
            data_r       <= data_s;
            cmd_ack_r    <= cmd_ack_s;
            rx_nak_r     <= rx_nak_s;
            al_r         <= al_s;
            busy_r       <= busy_s;
            bytes_done_r <= bytes_done_s;
            bit_cmd_r    <= bit_cmd_s;
            bit_din_r    <= bit_din_s;
        end
    end

    assign o_data       = data_r;
    assign o_cmd_ack    = cmd_ack_r;
    assign o_rx_nak     = rx_nak_r;
    assign o_al         = al_r;
    assign o_busy       = busy_r;
    assign o_bytes_done = bytes_done_r;
    assign o_bit_cmd    = bit_cmd_r;
    assign o_bit_din    = bit_din_r;

endmodule

// File: doc/i2c_master_word_ctl.md
Name: i2c_master_word_ctl

Overview:
Parametrised byte/word sequencer for the I2C master, one level above the bit controller. A single command moves NBYTES bytes, MSB first, with per-byte ACK handling. On writes it samples the slave ACK; on reads it drives the master ACK/NAK. It detects NAK and arbitration loss and aborts cleanly. It drives the bit controller through a cmd/done handshake exposed as ports, and is instanced between the register file and the bit controller.

Parameters:
NBYTES, 2, bytes per WRITE/READ command (1..4); DATA_W = 8*NBYTES (derived, not overridable)
STOP_ON_NAK, 1, 1: a WRITE aborts after the first slave NAK; 0: all bytes are sent regardless
CW, $clog2(NBYTES+1), width of the byte-count output

Ports:
i_sysclk  in  1  system clock
i_nReset  in  1  asynchronous active-low reset
i_enable  in  1  core enable; low = synchronous abort to IDLE
i_cmd_trig  in  1  single-cycle command strobe
i_cmd  in  3  0 IDLE, 1 START, 2 STOP, 3 WRITE, 4 READ, 5 RESTART
i_last_nak  in  1  READ: master sends NAK after the final byte (else ACK)
i_data  in  DATA_W  write data, latched on an accepted trigger
o_data  out  DATA_W  read data
o_cmd_ack  out  1  one-cycle pulse when a command completes or aborts
o_rx_nak  out  1  slave ACK bit of the last written byte (1 = NAK)
o_al  out  1  arbitration lost, sticky until the next accepted trigger
o_busy  out  1  state != IDLE
o_bytes_done  out  CW  bytes fully completed by the last WRITE/READ
o_bit_cmd  out  3  bit-controller command, same encoding as i_cmd (no 5 = RESTART is bit-level too)
o_bit_din  out  1  bit to drive
i_bit_done  in  1  bit-controller completion pulse
i_bit_dout  in  1  sampled SDA bit
i_arblost  in  1  bit-controller arbitration-lost pulse

Behaviour:
- Reset values: o_data=all 1s; o_cmd_ack=0; o_rx_nak=0; o_al=0; o_busy=0; o_bytes_done=0; o_bit_cmd=0; o_bit_din=1. State=IDLE, shift reg=all 1s, bit_cnt=7, byte_cnt=0.
- States: IDLE, START, STOP, RESTART, WR_BIT, WR_ACK, RD_BIT, RD_ACK.
- Trigger accepted only in IDLE with i_enable=1. A trigger while busy is ignored with no side effects.
- Trigger with i_cmd=0 or 6/7: no state change, no ack.
- Latency: o_bit_cmd is valid on the cycle after an accepted trigger. It is held stable until i_bit_done. Each next bit command is issued on the cycle after i_bit_done, so there is one IDLE-free gap cycle.
- START/STOP/RESTART: issue the matching bit command. On i_bit_done go to IDLE, pulse o_cmd_ack next cycle, o_bit_cmd=0.
- WRITE: shift=i_data, byte_cnt=0, o_al cleared.
  - WR_BIT sends bit-cmd WRITE with o_bit_din=shift[DATA_W-1]. Shift left, filling with 1, on each done. After 8 dones go to WR_ACK.
  - WR_ACK issues bit-cmd READ with o_bit_din=1. On done: o_rx_nak=i_bit_dout, byte_cnt++.
  - If byte_cnt reaches NBYTES, or (STOP_ON_NAK and i_bit_dout=1): finish. Otherwise return to WR_BIT.
- READ: byte_cnt=0.
  - RD_BIT issues bit-cmd READ with o_bit_din=1. Shift in i_bit_dout at the LSB on each done.
  - After 8 dones go to RD_ACK, which issues bit-cmd WRITE. o_bit_din=1 if (final byte and i_last_nak), else 0.
  - After the final RD_ACK done, o_data=shift register.
- Finish: o_bytes_done=byte_cnt, o_cmd_ack pulses one cycle, state IDLE, o_bit_cmd=0.
- i_arblost (any state != IDLE): next cycle state IDLE, o_bit_cmd=0, o_al=1, o_cmd_ack pulses. o_bytes_done=bytes completed so far. o_data unchanged.
- i_arblost and i_bit_done in the same cycle: arblost wins.
- i_enable=0: state IDLE, o_bit_cmd=0, o_bit_din=1, no ack pulse. o_data/o_rx_nak/o_al/o_bytes_done hold.
- i_bit_done in IDLE: ignored.
- Async reset mid-transfer: immediate return to reset values, no ack.

Test Plan:
- NBYTES=2: START, then WRITE 0xA55A with slave ACK on both bytes -> o_bit_din sequence 1010_0101 / 0101_1010, two WR_ACK reads, o_rx_nak=0, o_bytes_done=2, one o_cmd_ack per command.
- STOP_ON_NAK=1: WRITE 0x1234, slave NAKs byte 0 -> only 9 bit commands issued, o_rx_nak=1, o_bytes_done=1. Repeat with STOP_ON_NAK=0 -> 18 bit commands, o_bytes_done=2.
- READ, slave drives 0xC3 then 0x7E, i_last_nak=1 -> o_data=0xC37E, master ACK bits 0 then 1, o_bytes_done=2.
- i_arblost pulse on the 4th bit of a WRITE -> o_al=1, o_cmd_ack pulse, o_busy=0 next cycle, o_bytes_done=0. Next trigger clears o_al.
- Trigger during a READ and i_cmd=7 in IDLE -> both ignored, no extra ack. i_enable dropped mid-READ -> IDLE, no ack, o_data unchanged.
- Reset asserted mid-WRITE -> all outputs at reset values; a START after release completes normally.
